// File: rtl/morse_pkg.sv
// Purpose: shared Morse constants, FSM state encoding and the ASCII -> Morse code table.
// Latency: n/a (package; morse_code() is pure combinational).
// Backpressure: n/a.
package morse_pkg;

  // Durations in Morse units.
  localparam logic [2:0] DOT_U   = 3'd1;
  localparam logic [2:0] DASH_U  = 3'd3;
  localparam logic [2:0] ELGAP_U = 3'd1;
  localparam logic [2:0] CHGAP_U = 3'd3;
  localparam logic [2:0] WGAP_U  = 3'd4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_ELGAP,
    S_CHGAP,
    S_WGAP
  } morse_state_e;

  // Element i (sent i-th, i=0 first) is pat[i]; 1 = dash. len = number of elements.
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pat;
  } morse_code_t;

  // Same symbol format as the decoder ROM, so an encoder/decoder loopback is exact.
  function automatic morse_code_t morse_code(input logic [7:0] ascii);
    logic [7:0]  c;
    logic [7:0]  sym;  // {len, pat}; len == 0 marks "no code"
    morse_code_t r;
    c = ascii;
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;  // fold lower case onto upper case
    case (c)
      "A": sym = {3'd2, 5'd2};   "B": sym = {3'd4, 5'd1};
      "C": sym = {3'd4, 5'd5};   "D": sym = {3'd3, 5'd1};
      "E": sym = {3'd1, 5'd0};   "F": sym = {3'd4, 5'd4};
      "G": sym = {3'd3, 5'd3};   "H": sym = {3'd4, 5'd0};
      "I": sym = {3'd2, 5'd0};   "J": sym = {3'd4, 5'd14};
      "K": sym = {3'd3, 5'd5};   "L": sym = {3'd4, 5'd2};
      "M": sym = {3'd2, 5'd3};   "N": sym = {3'd2, 5'd1};
      "O": sym = {3'd3, 5'd7};   "P": sym = {3'd4, 5'd6};
      "Q": sym = {3'd4, 5'd11};  "R": sym = {3'd3, 5'd2};
      "S": sym = {3'd3, 5'd0};   "T": sym = {3'd1, 5'd1};
      "U": sym = {3'd3, 5'd4};   "V": sym = {3'd4, 5'd8};
      "W": sym = {3'd3, 5'd6};   "X": sym = {3'd4, 5'd9};
      "Y": sym = {3'd4, 5'd13};  "Z": sym = {3'd4, 5'd3};
      "0": sym = {3'd5, 5'd31};  "1": sym = {3'd5, 5'd30};
      "2": sym = {3'd5, 5'd28};  "3": sym = {3'd5, 5'd24};
      "4": sym = {3'd5, 5'd16};  "5": sym = {3'd5, 5'd0};
      "6": sym = {3'd5, 5'd1};   "7": sym = {3'd5, 5'd3};
      "8": sym = {3'd5, 5'd7};   "9": sym = {3'd5, 5'd15};
      default: sym = 8'h00;
    endcase
    r.valid = (sym[7:5] != 3'd0);
    r.len   = sym[7:5];
    r.pat   = sym[4:0];
    return r;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Purpose: counts a loaded number of Morse units (1..4) of DOT_TICKS cycles each.
// Latency: done_o is high in the last cycle of the period, units_i*DOT_TICKS cycles after load_i.
// Backpressure: none; load_i restarts the period at tick 0, run_i=0 holds the counters.
// Ports: clk, reset (async, active-high), load_i/units_i (start period), run_i (count enable),
//        done_o (combinational, last cycle of the period).
module morse_unit_timer #(
  parameter int DOT_TICKS = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       run_i,
  input  logic [2:0] units_i,
  output logic       done_o
);

  localparam int TW = $clog2(DOT_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(DOT_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    unit_q, unit_d;
  logic [1:0]    last_q, last_d;  // index of the final unit of this period

  always_comb begin
    tick_d = tick_q;
    unit_d = unit_q;
    last_d = last_q;
    if (load_i) begin
      tick_d = '0;
      unit_d = '0;
      last_d = 2'(units_i - 3'd1);
    end else if (run_i) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        unit_d = unit_q + 2'd1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
      unit_q <= '0;
      last_q <= '0;
    end else begin
      tick_q <= tick_d;
      unit_q <= unit_d;
      last_q <= last_d;
    end
  end

  assign done_o = (tick_q == TICK_LAST) && (unit_q == last_q);

endmodule

// File: rtl/ascii_to_morse.sv
// Purpose: accepts one ASCII byte per valid/ready handshake and keys it out as Morse on 'key'.
// Latency: accept at edge N -> key=1 from cycle N+1; ready again the cycle after the trailing gap.
// Backpressure: ascii_ready=0 in every non-IDLE state; a held ascii_valid waits, unconsumed.
// Ports: clk, reset (async, active-high), ascii_in/ascii_valid/ascii_ready (input handshake),
//        key (registered mark output), busy (state != IDLE), err (one-cycle pulse, no code).
module ascii_to_morse
  import morse_pkg::*;
#(
  parameter int DOT_TICKS = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       key,
  output logic       busy,
  output logic       err
);

  morse_state_e state_q, state_d;
  logic [2:0]   elem_q, elem_d;
  logic [2:0]   len_q, len_d;
  logic [4:0]   pat_q, pat_d;
  logic         key_q, key_d;
  logic         err_q, err_d;
  logic [2:0]   units;
  logic         accept;
  logic         tmr_done;
  morse_code_t  cd;

  assign ascii_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign accept      = ascii_valid & ascii_ready;
  assign cd          = morse_code(ascii_in);

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    len_d   = len_q;
    pat_d   = pat_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ascii_in == ASCII_SPACE) begin
            state_d = S_WGAP;
          end else if (cd.valid) begin
            len_d   = cd.len;
            pat_d   = cd.pat;
            elem_d  = '0;
            state_d = S_MARK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (tmr_done) begin
          // More elements follow only if elem+1 < len.
          if (({1'b0, elem_q} + 4'd1) < {1'b0, len_q}) state_d = S_ELGAP;
          else                                          state_d = S_CHGAP;
        end
      end
      S_ELGAP: begin
        if (tmr_done) begin
          elem_d  = elem_q + 3'd1;
          state_d = S_MARK;
        end
      end
      S_CHGAP, S_WGAP: begin
        if (tmr_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Period length of the state being entered; the timer loads it on the transition edge.
    case (state_d)
      S_MARK:  units = pat_d[elem_d] ? DASH_U : DOT_U;
      S_ELGAP: units = ELGAP_U;
      S_CHGAP: units = CHGAP_U;
      S_WGAP:  units = WGAP_U;
      default: units = DOT_U;
    endcase

    // key follows the next state so it is registered alongside state_q with no extra delay.
    key_d = (state_d == S_MARK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      key_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  morse_unit_timer #(
    .DOT_TICKS (DOT_TICKS)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_d != state_q),
    .run_i   (busy),
    .units_i (units),
    .done_o  (tmr_done)
  );

  assign key = key_q;
  assign err = err_q;

endmodule

// File: tb/tb_ascii_to_morse.sv
// Purpose: self-checking bench for ascii_to_morse with DOT_TICKS=4.
// Latency: expected key waveform is queued per character and compared cycle by cycle.
// Backpressure: back-to-back case holds ascii_valid high across busy periods.
module tb_ascii_to_morse;

  localparam int DT = 4;

  logic       clk;
  logic       reset;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       key;
  logic       busy;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_q[$];

  ascii_to_morse #(.DOT_TICKS(DT)) dut (
    .clk         (clk),
    .reset       (reset),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .key         (key),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_n(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Expected key waveform of one character from its dot/dash string.
  task automatic push_char(input string m);
    for (int i = 0; i < m.len(); i++) begin
      push_n(1'b1, (m[i] == "-") ? 3 * DT : DT);
      if (i < m.len() - 1) push_n(1'b0, DT);
    end
    push_n(1'b0, 3 * DT);
  endtask

  // Called at a falling edge: present c, wait (bounded) for ready, let the edge accept it.
  task automatic accept(input logic [7:0] c, input bit keep_valid);
    bit got;
    got = 1'b0;
    ascii_in    = c;
    ascii_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ascii_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_ready_timeout", got, 1'b1);
    @(posedge clk);
    #1;
    if (!keep_valid) ascii_valid = 1'b0;
  endtask

  // Compare every queued key cycle, then the first IDLE cycle.
  task automatic drain(input string tag);
    bit e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_key"}, key, e);
      check({tag, "_ready_low"}, ascii_ready, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_err_quiet"}, err, 1'b0);
    end
    @(negedge clk);
    check({tag, "_ready_back"}, ascii_ready, 1'b1);
    check({tag, "_idle_key"}, key, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    ascii_in    = 8'h00;
    ascii_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_key", key, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", ascii_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ascii_ready, 1'b1);

    // Single dot.
    push_char(".");
    accept("E", 1'b0);
    drain("E");

    // Lower case folds onto upper case.
    push_char(".-");
    accept("a", 1'b0);
    drain("a");
    push_char(".-");
    accept("A", 1'b0);
    drain("A");

    // Five dashes, longest character.
    push_char("-----");
    accept("0", 1'b0);
    drain("zero");

    // "E E" with valid held: the held byte is only taken in the first IDLE cycle.
    push_char(".");
    accept("E", 1'b1);
    ascii_in = " ";
    drain("EE_first");
    push_n(1'b0, 4 * DT);
    accept(" ", 1'b1);
    ascii_in = "E";
    drain("EE_space");
    push_char(".");
    accept("E", 1'b0);
    drain("EE_last");

    // Character with no code.
    accept("#", 1'b0);
    @(negedge clk);
    check("hash_err", err, 1'b1);
    check("hash_key", key, 1'b0);
    check("hash_ready", ascii_ready, 1'b1);
    check("hash_busy", busy, 1'b0);
    @(negedge clk);
    check("hash_err_pulse", err, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("hash_key_quiet", key, 1'b0);
      check("hash_err_quiet", err, 1'b0);
    end

    // Reset in the middle of the dash of 'T'.
    push_char("-");
    accept("T", 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("T_key_pre_rst", key, exp_q.pop_front());
    end
    reset = 1'b1;
    #1;
    check("T_rst_key_async", key, 1'b0);
    check("T_rst_busy", busy, 1'b0);
    check("T_rst_ready", ascii_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("T_no_resume_key", key, 1'b0);
      check("T_no_resume_busy", busy, 1'b0);
      check("T_no_resume_ready", ascii_ready, 1'b1);
    end

    // Normal operation after the mid-character reset.
    push_char("..");
    accept("i", 1'b0);
    drain("i_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
